// File: rtl/vdp_write_ctrl.sv
// Host write scheduler: assembles byte writes into 16-bit words, queues them,
// and drains them to the name/tile RAM write ports only while blank is high.
module vdp_write_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        dot_clk,
    input  logic        reset,
    input  logic        host_we,
    input  logic [1:0]  host_reg,
    input  logic [7:0]  host_data,
    output logic        host_ready,
    output logic        overflow,
    output logic        idle,
    input  logic        blank,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        name_we,
    output logic        tile_we
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = (PW)'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        target;
        logic [11:0] addr;
        logic [15:0] data;
    } wr_entry_t;

    wr_entry_t      fifo [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;

    logic [11:0] addr;
    logic        target;
    logic        noinc;
    logic [7:0]  dlo;

    logic        full, commit, push, pop;
    logic [11:0] push_addr, addr_inc;
    wr_entry_t   head;

    assign full   = (count == CNT_FULL);
    assign commit = host_we && (host_reg == 2'd3);
    assign push   = commit && !full;
    assign pop    = blank && (count != '0);
    assign head   = fifo[rd_ptr];

    // Tile RAM is 2K words: bit 11 is forced low and the address wraps at 2047.
    assign push_addr = target ? {1'b0, addr[10:0]} : addr;
    assign addr_inc  = target ? {1'b0, addr[10:0] + 11'd1} : addr + 12'd1;

    assign host_ready = !full;
    assign idle       = (count == '0) && !name_we && !tile_we;

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            target   <= 1'b0;
            noinc    <= 1'b0;
            dlo      <= '0;
            overflow <= 1'b0;
        end else if (host_we) begin
            case (host_reg)
                2'd0: addr[7:0] <= host_data;
                2'd1: begin
                    addr[11:8] <= host_data[3:0];
                    target     <= host_data[7];
                    noinc      <= host_data[6];
                    overflow   <= 1'b0;
                end
                2'd2: dlo <= host_data;
                default: begin
                    // A rejected commit leaves the address untouched.
                    if (full)        overflow <= 1'b1;
                    else if (!noinc) addr     <= addr_inc;
                end
            endcase
        end
    end

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge dot_clk) begin
        if (push) fifo[wr_ptr] <= '{target: target, addr: push_addr, data: {host_data, dlo}};
    end

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            name_we  <= 1'b0;
            tile_we  <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            name_we <= pop && !head.target;
            tile_we <= pop && head.target;
            if (pop) begin
                ram_addr <= head.addr;
                ram_data <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_vdp_write_ctrl.sv
// Directed bench for vdp_write_ctrl: expected RAM writes are queued on commit
// and a negedge monitor pops and compares every write-enable pulse.
module tb_vdp_write_ctrl;
    logic        dot_clk = 1'b0;
    logic        reset;
    logic        host_we;
    logic [1:0]  host_reg;
    logic [7:0]  host_data;
    logic        host_ready, overflow, idle, blank;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic        name_we, tile_we;

    int checks = 0;
    int errors = 0;
    logic [29:0] sb [$];

    vdp_write_ctrl #(.FIFO_DEPTH(4)) dut (
        .dot_clk(dot_clk), .reset(reset), .host_we(host_we), .host_reg(host_reg),
        .host_data(host_data), .host_ready(host_ready), .overflow(overflow),
        .idle(idle), .blank(blank), .ram_addr(ram_addr), .ram_data(ram_data),
        .name_we(name_we), .tile_we(tile_we)
    );

    always #5 dot_clk = ~dot_clk;

    function automatic logic [29:0] mk(input logic tile, input logic [11:0] a, input logic [15:0] d);
        return {tile, ~tile, a, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        host_we = 1'b1; host_reg = r; host_data = d;
        @(posedge dot_clk); #1;
        host_we = 1'b0;
    endtask

    task automatic commit(input logic tile, input logic [11:0] a, input logic [7:0] hi, input logic [7:0] lo);
        sb.push_back(mk(tile, a, {hi, lo}));
        wr(2'd3, hi);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(idle && sb.size() == 0) && n < 100) begin
            @(negedge dot_clk);
            n++;
        end
        chk(name, {31'd0, idle && sb.size() == 0}, 32'd1);
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge dot_clk) begin
        if (!reset && (name_we || tile_we)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: tile=%0b name=%0b addr=0x%0h data=0x%0h",
                         tile_we, name_we, ram_addr, ram_data);
            end else begin
                logic [29:0] e;
                e = sb.pop_front();
                if ({tile_we, name_we, ram_addr, ram_data} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got tile=%0b name=%0b addr=0x%0h data=0x%0h expected tile=%0b name=%0b addr=0x%0h data=0x%0h",
                             tile_we, name_we, ram_addr, ram_data, e[29], e[28], e[27:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; host_we = 1'b0; host_reg = '0; host_data = '0; blank = 1'b0;
        #12;
        chk("rst_name_we", {31'd0, name_we}, 0);
        chk("rst_tile_we", {31'd0, tile_we}, 0);
        chk("rst_ram_addr", {20'd0, ram_addr}, 0);
        chk("rst_ram_data", {16'd0, ram_data}, 0);
        chk("rst_host_ready", {31'd0, host_ready}, 1);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_idle", {31'd0, idle}, 1);
        @(negedge dot_clk); reset = 1'b0;
        @(posedge dot_clk); #1;

        // Basic commit, then the address has advanced to 0x511.
        blank = 1'b1;
        wr(2'd1, 8'h05); wr(2'd0, 8'h10); wr(2'd2, 8'hAB);
        commit(1'b0, 12'h510, 8'hCD, 8'hAB);
        chk("idle_after_push", {31'd0, idle}, 0);
        wait_idle("basic_drain");
        commit(1'b0, 12'h511, 8'h22, 8'hAB);
        wait_idle("basic_next");

        // Blank gating: nothing leaves while blank is low.
        blank = 1'b0;
        wr(2'd1, 8'h00); wr(2'd0, 8'h20); wr(2'd2, 8'h00);
        commit(1'b0, 12'h020, 8'h01, 8'h00);
        commit(1'b0, 12'h021, 8'h02, 8'h00);
        commit(1'b0, 12'h022, 8'h03, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge dot_clk);
            chk("gated_we", {30'd0, name_we, tile_we}, 0);
        end
        chk("gated_idle", {31'd0, idle}, 0);
        @(posedge dot_clk); #1;
        blank = 1'b1;
        repeat (4) @(posedge dot_clk);
        #1;
        chk("gated_drain_3cyc", {31'd0, idle && sb.size() == 0}, 1);

        // Overflow: fifth commit is dropped and the address only advanced by four.
        blank = 1'b0;
        wr(2'd1, 8'h00); wr(2'd0, 8'h40); wr(2'd2, 8'h10);
        for (int i = 0; i < 4; i++) begin
            chk("ready_before_full", {31'd0, host_ready}, 1);
            commit(1'b0, 12'h040 + 12'(i), 8'(8'h20 + i), 8'h10);
        end
        chk("ready_full", {31'd0, host_ready}, 0);
        chk("ovf_before", {31'd0, overflow}, 0);
        wr(2'd3, 8'hEE);
        chk("ovf_set", {31'd0, overflow}, 1);
        wr(2'd1, 8'h00);
        chk("ovf_cleared", {31'd0, overflow}, 0);
        blank = 1'b1;
        @(posedge dot_clk); #1;
        chk("ready_after_pop", {31'd0, host_ready}, 1);
        wait_idle("ovf_drain");
        commit(1'b0, 12'h044, 8'h30, 8'h10);
        wait_idle("ovf_addr_next");

        // Tile target wraps 0x7FF -> 0x000.
        wr(2'd1, 8'h8F); wr(2'd0, 8'hFF); wr(2'd2, 8'h5A);
        commit(1'b1, 12'h7FF, 8'h01, 8'h5A);
        commit(1'b1, 12'h000, 8'h02, 8'h5A);
        wait_idle("tile_wrap");

        // No-increment, then 12-bit name wrap.
        wr(2'd1, 8'h4F); wr(2'd0, 8'hFF);
        commit(1'b0, 12'hFFF, 8'h03, 8'h5A);
        commit(1'b0, 12'hFFF, 8'h04, 8'h5A);
        wr(2'd1, 8'h0F); wr(2'd0, 8'hFF);
        commit(1'b0, 12'hFFF, 8'h05, 8'h5A);
        commit(1'b0, 12'h000, 8'h06, 8'h5A);
        wait_idle("noinc_wrap");

        // Async reset mid-drain discards queued words.
        blank = 1'b0;
        wr(2'd1, 8'h00); wr(2'd0, 8'h00); wr(2'd2, 8'h77);
        for (int i = 0; i < 4; i++) commit(1'b0, 12'(i), 8'(i), 8'h77);
        blank = 1'b1;
        @(posedge dot_clk);
        #7;
        chk("pre_reset_popped", sb.size(), 3);
        reset = 1'b1;
        #1;
        chk("async_we", {30'd0, name_we, tile_we}, 0);
        chk("async_ready", {31'd0, host_ready}, 1);
        chk("async_idle", {31'd0, idle}, 1);
        sb.delete();
        @(negedge dot_clk); reset = 1'b0;
        repeat (10) @(posedge dot_clk);
        #1;
        chk("post_reset_idle", {31'd0, idle}, 1);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vdp_write_ctrl.md
# vdp_write_ctrl

Host-side write scheduler for the VDP's video memories. Accepts byte-wide register writes from the CPU bus and assembles them into 16-bit words with an auto-incrementing address. Buffers the words in a small FIFO and commits them to the name RAM or tile RAM write port only while the display is blanked, so host updates never tear the active picture. Sits between the CPU bus decoder and the write ports of `nameram`/`tileram`, in the `dot_clk` domain.

## Interface
- `FIFO_DEPTH`, default 4: write-buffer entries; power of two, at least 2.
- `dot_clk`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `host_we`  in  1: one-cycle host register write strobe.
- `host_reg`  in  2: register select; 0 addr low, 1 addr high/control, 2 data low, 3 data high (commit).
- `host_data`  in  8: host write data.
- `host_ready`  out  1: high when the FIFO is not full.
- `overflow`  out  1: sticky; a commit was dropped because the FIFO was full.
- `idle`  out  1: FIFO empty and no RAM write in progress.
- `blank`  in  1: high outside the visible area; writes drain only while sampled high.
- `ram_addr`  out  12: write address to both RAMs.
- `ram_data`  out  16: write word; [15:8] name/high byte, [7:0] attribute/low byte.
- `name_we`  out  1: name RAM write enable.
- `tile_we`  out  1: tile RAM write enable.

## Operation
- Register 0 write: `addr[7:0] <= host_data`.
- Register 1 write: `addr[11:8] <= host_data[3:0]`; `target <= host_data[7]` (0 name RAM, 1 tile RAM); `noinc <= host_data[6]`; clears `overflow`.
- Register 2 write: `dlo <= host_data`.
- Register 3 write: if not full, push {target, addr, host_data, dlo} into the FIFO. Then, unless `noinc`, increment `addr`. If full, drop the word, set `overflow`, and leave `addr` unchanged.
- Address width and wrap:
  - Name target: 12-bit, 4095 -> 0.
  - Tile target: `addr[11]` is forced to 0 both on push and on increment, and the 11-bit address wraps 2047 -> 0.
- Drain: at each edge where `blank` = 1 and the FIFO is non-empty, pop the head entry into the output registers. The target's `*_we` is asserted for exactly that cycle. At most one pop per cycle.
- When nothing is popped, `name_we` = `tile_we` = 0. `ram_addr`/`ram_data` hold their last values.
- Push and pop in the same cycle (FIFO not full): level unchanged, order preserved.
- A commit while full is rejected even if a pop happens at the same edge. `host_ready` is the registered not-full flag.
- Writes to registers 0–2 are never blocked and do not affect queued entries.
- Reset values:
  - Outputs: `name_we` = `tile_we` = 0, `ram_addr` = 0, `ram_data` = 0, `host_ready` = 1, `overflow` = 0, `idle` = 1.
  - Internal state: `addr` = 0, `target` = 0, `noinc` = 0, `dlo` = 0, FIFO empty.
- Reset mid-operation: queued words are discarded and write enables drop immediately (asynchronous). No partial RAM write is retried.

## Timing
- Commit latency: a register-3 write sampled at edge E, with `blank` high at E+1, produces `*_we` high during the cycle after edge E+1. Minimum latency is 2 edges.
- `blank` falling: entries still queued stay queued. A write already launched at the last blank-high edge completes its single cycle.
- `host_ready` falls in the cycle after the commit that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.
- `idle` is low from the edge after a push until the cycle after the final `*_we` pulse.
- Drain throughput: one word per `dot_clk` while `blank` is high. A full FIFO of 4 empties in 4 cycles.

## Test plan
- Basic commit:
  - Stimulus: reset; reg1 = 0x05; reg0 = 0x10; reg2 = 0xAB; reg3 = 0xCD; `blank` = 1.
  - Response: one `name_we` pulse with `ram_addr` = 0x510 and `ram_data` = 0xCDAB. Afterwards `addr` reads back as 0x511 on the next commit.
- Blank gating:
  - Stimulus: `blank` = 0; commit 3 words; hold 20 cycles; then raise `blank`.
  - Response: no `*_we` while `blank` is low. Then 3 consecutive pulses in push order, and `idle` rises after the third.
- Overflow:
  - Stimulus: `blank` = 0; commit 5 words.
  - Response: `host_ready` = 0 after the 4th commit and `overflow` = 1 after the 5th. The 5th word is never written, and `addr` advanced by only 4. A subsequent reg1 write clears `overflow`.
- Tile target and wrap:
  - Stimulus: reg1 = 0x8F, reg0 = 0xFF (tile, addr 0x7FF); two commits with `blank` = 1.
  - Response: `tile_we` pulses at `ram_addr` = 0x7FF then 0x000, and `name_we` never asserts.
- No-increment and name wrap:
  - Stimulus: reg1 = 0x4F, reg0 = 0xFF; two commits. Then reg1 = 0x0F, reg0 = 0xFF; two commits.
  - Response: the first pair both write to 0xFFF. The second pair writes 0xFFF then 0x000.
- Async reset mid-drain:
  - Stimulus: 4 words queued; `blank` = 1; assert `reset` between clock edges after the first pulse.
  - Response: `*_we` drops immediately and `host_ready` = 1. No further writes occur after release.
